seq_match_counter: RTL and testbench



---
 rtl/seq_match_counter_pkg.sv | 21 ++
 rtl/seq_match_counter_if.sv | 10 +
 rtl/seg7_defs.vh | 15 +
 rtl/seq_match_counter_bcd_to_7seg.sv | 29 ++
 rtl/seq_match_counter.sv | 100 ++++++++++
 tb/tb_seq_match_counter.sv | 157 +++++++++++++++
 6 files changed

// File: rtl/seq_match_counter_pkg.sv
// Shared types and helpers for the "0110" detector's match counter stage.
package seq_match_counter_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    COUNTING   = 1'b0,
    OVERFLOWED = 1'b1
  } state_e;

  localparam bcd_t BCD_NINE = 4'd9;

  function automatic bcd_t tens_of(input int value);
    return bcd_t'(value / 10);
  endfunction

  function automatic bcd_t ones_of(input int value);
    return bcd_t'(value % 10);
  endfunction

endpackage

// File: rtl/seq_match_counter_if.sv
// Detector-facing and display-facing signals of the match counter.
interface seq_match_counter_if;
  logic       match;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [0:0] LEDG;

  modport master (output match, input HEX0, HEX1, LEDG);
  modport slave  (input match, output HEX0, HEX1, LEDG);
endinterface

// File: rtl/seg7_defs.vh
// Shared active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}, used by every HEX-driving lab.
`ifndef SEG7_DEFS_VH
`define SEG7_DEFS_VH
`define SEG_0     7'b1000000
`define SEG_1     7'b1111001
`define SEG_2     7'b0100100
`define SEG_3     7'b0110000
`define SEG_4     7'b0011001
`define SEG_5     7'b0010010
`define SEG_6     7'b0000010
`define SEG_7     7'b1111000
`define SEG_8     7'b0000000
`define SEG_9     7'b0010000
`define SEG_BLANK 7'b1111111
`endif

// File: rtl/seq_match_counter_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder; non-BCD nibbles blank the digit.
`include "seg7_defs.vh"

module bcd_to_7seg
  import seq_match_counter_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  // Digit pattern lookup
  always_comb begin
    seg = `SEG_BLANK;
    case (bcd)
      4'd0:    seg = `SEG_0;
      4'd1:    seg = `SEG_1;
      4'd2:    seg = `SEG_2;
      4'd3:    seg = `SEG_3;
      4'd4:    seg = `SEG_4;
      4'd5:    seg = `SEG_5;
      4'd6:    seg = `SEG_6;
      4'd7:    seg = `SEG_7;
      4'd8:    seg = `SEG_8;
      4'd9:    seg = `SEG_9;
      default: seg = `SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seq_match_counter.sv
// Counts rising edges of the detector match flag as 2-digit BCD and drives two HEX digits.
// Optional build macro SEQ_CNT_SATURATE_EN: hold at MAX_COUNT instead of wrapping to 00.
module seq_match_counter
  import seq_match_counter_pkg::*;
#(
  parameter int MAX_COUNT = 99
) (
  input  logic [3:3]          KEY,
  input  logic [1:1]          SW,
  seq_match_counter_if.slave  bus
);

  localparam bcd_t MAX_TENS = tens_of(MAX_COUNT);
  localparam bcd_t MAX_ONES = ones_of(MAX_COUNT);

  logic   clk;
  logic   rst_n;
  logic   match_q, match_d;
  bcd_t   ones_q, ones_d;
  bcd_t   tens_q, tens_d;
  state_e state_q, state_d;
  logic   step_s;
  logic   at_max_s;

  assign clk      = KEY[3];
  assign rst_n    = SW[1];
  assign step_s   = bus.match & ~match_q;
  assign at_max_s = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);

  // State registers advance on the push-button press (falling edge)
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      state_q <= COUNTING;
    end else begin
      match_q <= match_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      state_q <= state_d;
    end
  end

  // BCD step on a match rising edge, with wrap or hold at MAX_COUNT
  always_comb begin
    match_d = bus.match;
    ones_d  = ones_q;
    tens_d  = tens_q;
    if (step_s && at_max_s) begin
`ifdef SEQ_CNT_SATURATE_EN
      ones_d = ones_q;
      tens_d = tens_q;
`else
      ones_d = 4'd0;
      tens_d = 4'd0;
`endif
    end else if (step_s) begin
      if (ones_q == BCD_NINE) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
        tens_d = tens_q;
      end
    end else begin
      ones_d = ones_q;
      tens_d = tens_q;
    end
  end

  // Overflow FSM: once past MAX_COUNT the LED stays lit until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      COUNTING: begin
        if (step_s && at_max_s) begin
          state_d = OVERFLOWED;
        end else begin
          state_d = COUNTING;
        end
      end
      OVERFLOWED: state_d = OVERFLOWED;
      default:    state_d = COUNTING;
    endcase
  end

  assign bus.LEDG[0] = (state_q == OVERFLOWED);

  bcd_to_7seg u_ones_seg (
    .bcd (ones_q),
    .seg (bus.HEX0)
  );

  bcd_to_7seg u_tens_seg (
    .bcd (tens_q),
    .seg (bus.HEX1)
  );

endmodule

// File: tb/tb_seq_match_counter.sv
// Self-checking bench for seq_match_counter: directed steps plus random match traffic vs. a counting model.
module tb_seq_match_counter;

  localparam int MAX_COUNT = 99;

  logic [3:3] key;
  logic [1:1] sw;
  int checks = 0;
  int errors = 0;

  // Reference model: plain decimal count, previous match level, overflow flag
  int model_count = 0;
  bit model_prev  = 1'b0;
  bit model_ovf   = 1'b0;

  seq_match_counter_if bus_if ();

  seq_match_counter #(.MAX_COUNT(MAX_COUNT)) dut (
    .KEY (key),
    .SW  (sw),
    .bus (bus_if.slave)
  );

  initial key[3] = 1'b1;
  always #5 key[3] = ~key[3];

  function automatic logic [6:0] seg_of(input int digit);
    logic [6:0] table_v [10];
    table_v = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return table_v[digit];
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".HEX0"}, bus_if.HEX0, seg_of(model_count % 10));
    chk({tag, ".HEX1"}, bus_if.HEX1, seg_of(model_count / 10));
    chk({tag, ".LEDG"}, {6'd0, bus_if.LEDG[0]}, {6'd0, model_ovf});
  endtask

  task automatic model_reset();
    model_count = 0;
    model_prev  = 1'b0;
    model_ovf   = 1'b0;
  endtask

  // One falling edge with match=m; outputs checked half a period later
  task automatic tick(input bit m, input string tag);
    bus_if.match = m;
    @(negedge key[3]);
    @(posedge key[3]);
    #1;
    if (sw[1]) begin
      if (m && !model_prev) begin
        if (model_count == MAX_COUNT) begin
`ifdef SEQ_CNT_SATURATE_EN
          model_count = MAX_COUNT;
`else
          model_count = 0;
`endif
          model_ovf = 1'b1;
        end else begin
          model_count = model_count + 1;
        end
      end
      model_prev = m;
    end else begin
      model_reset();
    end
    check_all(tag);
  endtask

  task automatic pulses(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, tag);
      tick(1'b0, tag);
    end
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge key[3]);
    #2;
    sw[1] = 1'b0;
    #1;
    model_reset();
    check_all(tag);
  endtask

  task automatic release_reset();
    @(posedge key[3]);
    #2;
    sw[1] = 1'b1;
  endtask

  initial begin
    sw[1] = 1'b0;
    bus_if.match = 1'b1;
    #1;
    check_all("reset_initial");

    // 1. reset held, match high, clock running
    for (int i = 0; i < 4; i++) tick(1'b1, "reset_held");

    // 2. match already high at release counts at the first edge
    release_reset();
    tick(1'b1, "first_edge_after_reset");
    tick(1'b0, "pulse_low");
    chk("one_pulse.HEX0", bus_if.HEX0, 7'b1111001);

    // 3. long match counts once, then a second rise
    for (int i = 0; i < 5; i++) tick(1'b1, "held_high");
    tick(1'b0, "held_release");
    chk("held_once.HEX0", bus_if.HEX0, 7'b0100100);
    tick(1'b1, "second_rise");
    tick(1'b0, "second_rise_low");

    // 4. BCD carry to 10
    async_reset_check("reset_before_carry");
    bus_if.match = 1'b0;
    release_reset();
    pulses(10, "carry");
    chk("carry.HEX1", bus_if.HEX1, 7'b1111001);
    chk("carry.HEX0", bus_if.HEX0, 7'b1000000);

    // 5. 100 pulses: overflow, then 3 more
    async_reset_check("reset_before_ovf");
    release_reset();
    pulses(100, "to_overflow");
    chk("ovf.LEDG", {6'd0, bus_if.LEDG[0]}, 7'd1);
    pulses(3, "after_overflow");

    // 6. count at 37, asynchronous reset, release with match high
    async_reset_check("reset_before_37");
    release_reset();
    pulses(37, "to_37");
    chk("at37.HEX1", bus_if.HEX1, 7'b0110000);
    bus_if.match = 1'b1;
    async_reset_check("async_clear_37");
    release_reset();
    tick(1'b1, "release_match_high");
    tick(1'b0, "release_match_low");

    // Random match traffic, long enough to cross MAX_COUNT
    for (int i = 0; i < 600; i++) tick(1'($urandom_range(0, 1)), "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
